// File: rtl/multicycle_ctrl.sv
// Multicycle CPU control FSM: IF/ID/EX/MEM/WB sequencing with memory-wait timeout and sticky error.
// Optional retired-instruction counter on instret_o when MC_INSTRET_EN is defined.
module multicycle_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [6:0]  opcode_i,
  input  logic        zero_i,
  input  logic        mem_ack_i,
  output logic        imem_req_o,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic        ir_we_o,
  output logic        pc_we_o,
  output logic        pc_sel_o,
  output logic        alu_src_o,
  output logic [1:0]  alu_op_o,
  output logic        reg_we_o,
  output logic        wb_sel_o,
  output logic [2:0]  state_o,
`ifdef MC_INSTRET_EN
  output logic [31:0] instret_o,
`endif
  output logic        err_o
);

  localparam int unsigned CNT_W = $clog2(MEM_TIMEOUT + 1);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EX  = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4,
    S_ERR = 3'd7
  } state_t;

  state_t             state_q, state_nxt;
  logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_nxt;
  logic               run_q;
  logic               timeout;
  logic               is_load, is_store, legal;

  assign is_load  = (opcode_i == OP_LOAD);
  assign is_store = (opcode_i == OP_STORE);
  assign legal    = (opcode_i == OP_R) || (opcode_i == OP_I) || is_load || is_store ||
                    (opcode_i == OP_BRANCH);
  assign timeout  = (wait_cnt_q == CNT_W'(MEM_TIMEOUT - 1));
  assign state_o  = state_q;

  // run_q holds the FSM idle (outputs low) until the first clock edge after reset release
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= S_IF;
      wait_cnt_q <= '0;
      run_q      <= 1'b0;
    end else begin
      run_q <= 1'b1;
      if (run_q) begin
        state_q    <= state_nxt;
        wait_cnt_q <= wait_cnt_nxt;
      end
    end
  end

  // Next state and all combinational outputs
  always_comb begin
    state_nxt    = state_q;
    wait_cnt_nxt = '0;
    imem_req_o   = 1'b0;
    dmem_req_o   = 1'b0;
    dmem_we_o    = 1'b0;
    ir_we_o      = 1'b0;
    pc_we_o      = 1'b0;
    pc_sel_o     = 1'b0;
    alu_src_o    = 1'b0;
    alu_op_o     = 2'b00;
    reg_we_o     = 1'b0;
    wb_sel_o     = 1'b0;
    err_o        = 1'b0;
    case (state_q)
      S_IF: begin
        imem_req_o = 1'b1;
        if (mem_ack_i) begin
          ir_we_o   = 1'b1;
          pc_we_o   = 1'b1;
          state_nxt = S_ID;
        end else if (timeout) begin
          state_nxt = S_ERR;
        end else begin
          wait_cnt_nxt = CNT_W'(wait_cnt_q + 1'b1);
        end
      end
      S_ID: state_nxt = legal ? S_EX : S_ERR;
      S_EX: begin
        case (opcode_i)
          OP_R: begin
            alu_op_o  = 2'b10;
            state_nxt = S_WB;
          end
          OP_I: begin
            alu_op_o  = 2'b10;
            alu_src_o = 1'b1;
            state_nxt = S_WB;
          end
          OP_LOAD, OP_STORE: begin
            alu_src_o = 1'b1;
            state_nxt = S_MEM;
          end
          OP_BRANCH: begin
            alu_op_o  = 2'b01;
            pc_we_o   = zero_i;
            pc_sel_o  = zero_i;
            state_nxt = S_IF;
          end
          default: state_nxt = S_ERR;
        endcase
      end
      S_MEM: begin
        dmem_req_o = 1'b1;
        dmem_we_o  = is_store;
        if (mem_ack_i) begin
          state_nxt = is_load ? S_WB : S_IF;
        end else if (timeout) begin
          state_nxt = S_ERR;
        end else begin
          wait_cnt_nxt = CNT_W'(wait_cnt_q + 1'b1);
        end
      end
      S_WB: begin
        reg_we_o  = 1'b1;
        wb_sel_o  = is_load;
        state_nxt = S_IF;
      end
      S_ERR: err_o = 1'b1;
      default: state_nxt = S_ERR;
    endcase
    if (!run_q) begin
      imem_req_o = 1'b0;
      dmem_req_o = 1'b0;
      dmem_we_o  = 1'b0;
      ir_we_o    = 1'b0;
      pc_we_o    = 1'b0;
      pc_sel_o   = 1'b0;
      alu_src_o  = 1'b0;
      alu_op_o   = 2'b00;
      reg_we_o   = 1'b0;
      wb_sel_o   = 1'b0;
      err_o      = 1'b0;
    end
  end

`ifdef MC_INSTRET_EN
  logic retire;
  assign retire = run_q && (state_nxt == S_IF) &&
                  ((state_q == S_WB) || (state_q == S_MEM) || (state_q == S_EX));

  // Retired-instruction count, wraps naturally at 32 bits
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) instret_o <= '0;
    else if (retire) instret_o <= instret_o + 32'd1;
  end
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: expected per-cycle traces are generated from instruction-level rules.
// Builds with or without MC_INSTRET_EN.
module tb_multicycle_ctrl;

  localparam int unsigned TO = 16;
  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LD = 7'b0000011,
                         OP_ST = 7'b0100011, OP_BR = 7'b1100011, OP_BAD = 7'b1111111;

  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  logic [6:0] opcode_i = 7'd0;
  logic zero_i = 1'b0;
  logic mem_ack_i = 1'b0;
  logic imem_req_o, dmem_req_o, dmem_we_o, ir_we_o, pc_we_o, pc_sel_o, alu_src_o;
  logic [1:0] alu_op_o;
  logic reg_we_o, wb_sel_o, err_o;
  logic [2:0] state_o;
`ifdef MC_INSTRET_EN
  logic [31:0] instret_o;
`endif

  multicycle_ctrl #(.MEM_TIMEOUT(TO)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .opcode_i(opcode_i), .zero_i(zero_i), .mem_ack_i(mem_ack_i),
    .imem_req_o(imem_req_o), .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .ir_we_o(ir_we_o),
    .pc_we_o(pc_we_o), .pc_sel_o(pc_sel_o), .alu_src_o(alu_src_o), .alu_op_o(alu_op_o),
    .reg_we_o(reg_we_o), .wb_sel_o(wb_sel_o), .state_o(state_o),
`ifdef MC_INSTRET_EN
    .instret_o(instret_o),
`endif
    .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [6:0]  opc;
    logic        zero;
    logic        ack;
    logic [2:0]  st;
    logic        imem, dmem, dwe, irwe, pcwe, pcsel, alusrc;
    logic [1:0]  aluop;
    logic        regwe, wbsel, err;
    logic [31:0] iret;
  } cyc_t;

  cyc_t q[$];
  int total = 0;
  int bad = 0;
  int cyc_no = 0;
  logic [31:0] m_iret = 32'd0;

  function automatic cyc_t mk(input logic [2:0] st, input logic [6:0] opc, input logic ack);
    cyc_t c;
    c = '0;
    c.st = st; c.opc = opc; c.ack = ack; c.iret = m_iret;
    return c;
  endfunction

  function automatic logic [14:0] exp_vec(input cyc_t c);
    return {c.st, c.imem, c.dmem, c.dwe, c.irwe, c.pcwe, c.pcsel, c.alusrc, c.aluop,
            c.regwe, c.wbsel, c.err};
  endfunction

  function automatic logic [14:0] act_vec();
    return {state_o, imem_req_o, dmem_req_o, dmem_we_o, ir_we_o, pc_we_o, pc_sel_o, alu_src_o,
            alu_op_o, reg_we_o, wb_sel_o, err_o};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_err(input int n, input logic [6:0] opc);
    cyc_t c;
    for (int i = 0; i < n; i++) begin
      c = mk(3'd7, opc, 1'(i % 2)); c.err = 1'b1; q.push_back(c);
    end
  endtask

  // Expected trace for one instruction; iw/dw are no-ack cycles before the ack (>= TO means timeout)
  task automatic push_instr(input logic [6:0] opc, input int iw, input int dw,
                            input logic zero, input logic noise);
    cyc_t c;
    bit ld, st, br;
    ld = (opc == OP_LD); st = (opc == OP_ST); br = (opc == OP_BR);
    for (int i = 0; i < ((iw >= int'(TO)) ? int'(TO) : iw); i++) begin
      c = mk(3'd0, opc, 1'b0); c.imem = 1'b1; q.push_back(c);
    end
    if (iw >= int'(TO)) begin push_err(6, opc); return; end
    c = mk(3'd0, opc, 1'b1); c.imem = 1'b1; c.irwe = 1'b1; c.pcwe = 1'b1; q.push_back(c);
    c = mk(3'd1, opc, noise); q.push_back(c);
    if (!(opc == OP_R || opc == OP_I || ld || st || br)) return;
    c = mk(3'd2, opc, noise); c.zero = zero;
    if (opc == OP_R) c.aluop = 2'b10;
    else if (opc == OP_I) begin c.aluop = 2'b10; c.alusrc = 1'b1; end
    else if (ld || st) c.alusrc = 1'b1;
    else begin c.aluop = 2'b01; c.pcwe = zero; c.pcsel = zero; end
    q.push_back(c);
    if (br) begin m_iret++; return; end
    if (ld || st) begin
      for (int i = 0; i < ((dw >= int'(TO)) ? int'(TO) : dw); i++) begin
        c = mk(3'd3, opc, 1'b0); c.dmem = 1'b1; c.dwe = st; q.push_back(c);
      end
      if (dw >= int'(TO)) begin push_err(6, opc); return; end
      c = mk(3'd3, opc, 1'b1); c.dmem = 1'b1; c.dwe = st; q.push_back(c);
      if (st) begin m_iret++; return; end
    end
    c = mk(3'd4, opc, noise); c.regwe = 1'b1; c.wbsel = ld; q.push_back(c);
    m_iret++;
  endtask

  // Drive and check every queued cycle; inputs change at negedge, outputs sampled 1ns later
  task automatic run_q();
    cyc_t c;
    while (q.size() > 0) begin
      c = q.pop_front();
      @(negedge clk_i);
      opcode_i = c.opc; zero_i = c.zero; mem_ack_i = c.ack;
      #1;
      cyc_no++;
      check($sformatf("cycle%0d_outputs", cyc_no), 64'(act_vec()), 64'(exp_vec(c)));
`ifdef MC_INSTRET_EN
      check($sformatf("cycle%0d_instret", cyc_no), 64'(instret_o), 64'(c.iret));
`endif
    end
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk_i);
    rst_i = 1'b0; mem_ack_i = 1'b1;
    #1;
    check({tag, "_assert"}, 64'(act_vec()), 64'd0);
    repeat (3) @(negedge clk_i);
    check({tag, "_hold"}, 64'(act_vec()), 64'd0);
`ifdef MC_INSTRET_EN
    check({tag, "_instret"}, 64'(instret_o), 64'd0);
`endif
    rst_i = 1'b1; mem_ack_i = 1'b0;
    #1;
    check({tag, "_release"}, 64'(act_vec()), 64'd0);
    m_iret = 32'd0;
  endtask

  int n0;

  initial begin
    do_reset("reset0");

    n0 = q.size(); push_instr(OP_R, 0, 0, 1'b0, 1'b0);
    check("lat_r", 64'(q.size() - n0), 64'd4);
    run_q();

    n0 = q.size(); push_instr(OP_LD, 3, 2, 1'b0, 1'b1);
    check("lat_load_waits", 64'(q.size() - n0), 64'd10);
    n0 = q.size(); push_instr(OP_I, 0, 0, 1'b0, 1'b1);
    check("lat_i", 64'(q.size() - n0), 64'd4);
    n0 = q.size(); push_instr(OP_ST, 0, 0, 1'b0, 1'b0);
    check("lat_store", 64'(q.size() - n0), 64'd4);
    n0 = q.size(); push_instr(OP_BR, 0, 0, 1'b1, 1'b0);
    check("lat_branch", 64'(q.size() - n0), 64'd3);
    push_instr(OP_BR, 1, 0, 1'b0, 1'b1);
    push_instr(OP_LD, 0, 0, 1'b0, 1'b0);
    check("model_instret", 64'(m_iret), 64'd7);
    run_q();

    push_instr(OP_R, TO - 1, 0, 1'b0, 1'b0);
    push_instr(OP_ST, 0, TO - 1, 1'b0, 1'b0);
    run_q();

    n0 = q.size(); push_instr(OP_R, TO, 0, 1'b0, 1'b0);
    check("if_timeout_len", 64'(q.size() - n0), 64'(TO + 6));
    run_q();
    do_reset("reset_if_to");

    push_instr(OP_LD, 0, TO, 1'b0, 1'b0);
    run_q();
    do_reset("reset_mem_to");

    push_instr(OP_R, 0, 0, 1'b0, 1'b0);
    push_instr(OP_BAD, 0, 0, 1'b0, 1'b0);
    push_err(20, OP_BAD);
    run_q();
    do_reset("reset_illegal");

    push_instr(OP_ST, 0, 3, 1'b0, 1'b0);
    void'(q.pop_back());
    void'(q.pop_back());
    m_iret = m_iret - 32'd1;
    run_q();
    @(negedge clk_i);
    #1;
    check("store_in_mem", 64'({state_o, dmem_req_o, dmem_we_o}), 64'({3'd3, 1'b1, 1'b1}));
    do_reset("reset_mid_store");

    push_instr(OP_I, 2, 0, 1'b0, 1'b1);
    run_q();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
